// File: rtl/chasy_pkg.sv
// Shared definitions for the chasy clock: button count, channel FSM states and
// default cycle constants for a 50 MHz system clock.
package chasy_pkg;

   localparam int NUM_BUTTONS         = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;   // 20 ms
   localparam int LONG_CYCLES_DEF     = 50_000_000;  // 1 s
   localparam int REPEAT_CYCLES_DEF   = 10_000_000;  // 200 ms

   typedef enum logic [1:0] {
      IDLE,
      DEB_PRESS,
      PRESSED,
      DEB_RELEASE
   } btn_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-FF synchronizer, debounce FSM and, when
// BUTTON_AUTOREPEAT_EN is defined, the long-press auto-repeat counter.
module button_channel
   import chasy_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic press,
   output logic held
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
      $fatal(1, "button_channel: cycle parameters must be >= 1");
   end

   logic       sync1, sync2;
   logic       pressed;
   btn_state_t state;
   logic [CW-1:0] cnt;

   // Pins idle high, so the synchronizer resets to the released level.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
      end
   end

   assign pressed = ~sync2;

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int RW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
   localparam logic [RW-1:0] LONG_LAST = RW'(LONG_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rcnt;
   logic          repeating;  // first interval after entry is LONG, then REPEAT
`endif

   // NOTE: every register here is assigned with <= so all next-state terms
   // read the values from before this edge, regardless of statement order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         press <= 1'b0;
         held  <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
         rcnt      <= '0;
         repeating <= 1'b0;
`endif
      end else begin
         press <= 1'b0;
         case (state)
            IDLE: begin
               if (pressed) begin
                  state <= DEB_PRESS;
                  cnt   <= '0;
               end
            end
            DEB_PRESS: begin
               if (!pressed) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state <= PRESSED;
                  press <= 1'b1;
                  held  <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                  rcnt      <= '0;
                  repeating <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!pressed) begin
                  state <= DEB_RELEASE;
                  cnt   <= '0;
               end
`ifdef BUTTON_AUTOREPEAT_EN
               else if (rcnt == (repeating ? REP_LAST : LONG_LAST)) begin
                  press     <= 1'b1;
                  rcnt      <= '0;
                  repeating <= 1'b1;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
`endif
            end
            DEB_RELEASE: begin
               // A bounce back to pressed resumes the hold without a new event.
               if (pressed) begin
                  state <= PRESSED;
`ifdef BUTTON_AUTOREPEAT_EN
                  rcnt      <= '0;
                  repeating <= 1'b0;
`endif
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  held  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the chasy push-buttons into press pulses and held levels.
// Auto-repeat on long press is compiled in with BUTTON_AUTOREPEAT_EN.
module button_conditioner
   import chasy_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [0:NUM_BUTTONS-1] button,
   output logic [0:NUM_BUTTONS-1] press,
   output logic [0:NUM_BUTTONS-1] held
);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_channel (
         .clock  (clock),
         .reset  (reset),
         .button (button[i]),
         .press  (press[i]),
         .held   (held[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: run-length reference model plus
// directed scenarios with hand-computed edge numbers.
module tb_button_conditioner;

   localparam int D = 4;
   localparam int L = 10;
   localparam int R = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic [0:3] button;
   logic [0:3] press;
   logic [0:3] held;

   button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .button (button),
      .press  (press),
      .held   (held)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %b, want %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: the FSM sees each pin two edges late; the accepted level
   // flips after D+1 consecutive disagreeing samples; repeats fall at L, L+R,
   // L+2R... edges after the latest entry into an uninterrupted hold.
   function automatic bit repeat_due(input int k);
`ifdef BUTTON_AUTOREPEAT_EN
      return (k == L) || (k > L && ((k - L) % R) == 0);
`else
      return (k < 0);
`endif
   endfunction

   logic [0:3] m_held, m_press, h0, h1, prev_p;
   int         dis [4];
   int         kk  [4];
   bit         model_live = 0;

   always @(posedge clock) begin
      if (!reset) begin
         h0         <= '1;
         h1         <= '1;
         m_held     <= '0;
         m_press    <= '0;
         prev_p     <= '0;
         model_live <= 1'b1;
         for (int i = 0; i < 4; i++) begin
            dis[i] <= 0;
            kk[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            automatic logic p     = ~h1[i];
            automatic logic nh    = m_held[i];
            automatic logic pulse = 1'b0;
            automatic int   d     = dis[i];
            automatic int   k     = kk[i];
            if (p != m_held[i]) begin
               d++;
               if (d == D + 1) begin
                  nh    = p;
                  pulse = p;
                  d     = 0;
                  k     = 0;
               end
            end else begin
               d = 0;
            end
            if (m_held[i] && p) begin
               if (!prev_p[i]) k = 0;
               else begin
                  k++;
                  if (repeat_due(k)) pulse = 1'b1;
               end
            end
            h1[i]      <= h0[i];
            h0[i]      <= button[i];
            m_held[i]  <= nh;
            m_press[i] <= pulse;
            prev_p[i]  <= p;
            dis[i]     <= d;
            kk[i]      <= k;
         end
      end
   end

   // Per-cycle comparison against the model plus pulse logging.
   int pulses[$];
   int watch = 0;
   int pcount[4] = '{0, 0, 0, 0};

   always @(negedge clock) begin
      if (model_live) begin
         check("model_press", press, m_press);
         check("model_held", held, m_held);
         for (int b = 0; b < 4; b++) begin
            if (press[b] === 1'b1) begin
               pcount[b]++;
               if (b == watch) pulses.push_back(cyc);
            end
         end
      end
   end

   task automatic wait_until(input int e);
      while (cyc < e) @(negedge clock);
   endtask

   task automatic check_pulses(input string name, input int exp[$]);
      check_int({name, "_count"}, pulses.size(), exp.size());
      for (int i = 0; i < exp.size() && i < pulses.size(); i++)
         check_int({name, "_edge"}, pulses[i], exp[i]);
   endtask

   function automatic int others(input int b);
      int s = 0;
      for (int i = 0; i < 4; i++) if (i != b) s += pcount[i];
      return s;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m, rr, o;
      int exp_q[$];

      // Reset held with all pins pressed.
      reset  = 1'b0;
      button = 4'b0000;
      repeat (5) begin
         @(negedge clock);
         check("rst_press", press, 4'b0000);
         check("rst_held", held, 4'b0000);
      end
      rr = cyc + 1;
      reset = 1'b1;
      wait_until(rr + 5);
      check("rel_press_early", press, 4'b0000);
      wait_until(rr + 6);
      check("rel_press", press, 4'b1111);
      check("rel_held", held, 4'b1111);
      button = 4'b1111;
      wait_until(rr + 12);
      check("rel_held_still", held, 4'b1111);
      wait_until(rr + 13);
      check("rel_held_fall", held, 4'b0000);
      wait_until(rr + 16);

      // Clean press on bit 1, 20 cycles low.
      watch = 1;
      pulses.delete();
      o = others(1);
      n = cyc + 1;
      m = n + 20;
      button[1] = 1'b0;
      wait_until(n + 5);
      check("clean_held_early", held, 4'b0000);
      wait_until(n + 6);
      check("clean_press", press, 4'b0100);
      check("clean_held_rise", held, 4'b0100);
      wait_until(m - 1);
      button[1] = 1'b1;
      wait_until(m + 5);
      check("clean_held_late", held, 4'b0100);
      wait_until(m + 6);
      check("clean_held_fall", held, 4'b0000);
      wait_until(m + 10);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_q = '{n + 6, n + 16, n + 19};
`else
      exp_q = '{n + 6};
`endif
      check_pulses("clean_pulses", exp_q);
      check_int("clean_other_bits", others(1), o);

      // Short pressed glitch on bit 2: rejected.
      watch = 2;
      pulses.delete();
      n = cyc + 1;
      button[2] = 1'b0;
      wait_until(n + 2);
      button[2] = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clock);
         check("bounce_held", held & 4'b0010, 4'b0000);
      end
      check_int("bounce_pulses", pulses.size(), 0);

      // Held press with a short released glitch: held stays, one pulse only.
      pulses.delete();
      n = cyc + 1;
      button[2] = 1'b0;
      for (int e = n; e <= n + 22; e++) begin
         wait_until(e);
         if (e >= n + 6 && e <= n + 20) check("glitch_held_on", held & 4'b0010, 4'b0010);
         else                           check("glitch_held_off", held & 4'b0010, 4'b0000);
         if (e == n + 7)  button[2] = 1'b1;
         if (e == n + 10) button[2] = 1'b0;
         if (e == n + 14) button[2] = 1'b1;
      end
      wait_until(n + 26);
      exp_q = '{n + 6};
      check_pulses("glitch_pulses", exp_q);

`ifdef BUTTON_AUTOREPEAT_EN
      // Long hold on bit 0 with auto-repeat.
      watch = 0;
      pulses.delete();
      n = cyc + 1;
      button[0] = 1'b0;
      wait_until(n + 26);
      button[0] = 1'b1;
      wait_until(n + 40);
      exp_q = '{n + 6, n + 16, n + 19, n + 22, n + 25, n + 28};
      check_pulses("repeat_pulses", exp_q);
`endif

      // Simultaneous press on bits 0 and 3.
      watch = 3;
      pulses.delete();
      n = cyc + 1;
      button = 4'b0110;
      wait_until(n + 5);
      check("simul_press_early", press, 4'b0000);
      wait_until(n + 6);
      check("simul_press", press, 4'b1001);
      wait_until(n + 7);
      button = 4'b1111;
      wait_until(n + 20);
      exp_q = '{n + 6};
      check_pulses("simul_pulses_b3", exp_q);

      // Reset while bit 1 is held, pin kept low through reset release.
      n = cyc + 1;
      button[1] = 1'b0;
      wait_until(n + 8);
      check("midrst_held_before", held, 4'b0100);
      reset = 1'b0;
      wait_until(n + 9);
      check("midrst_held", held, 4'b0000);
      check("midrst_press", press, 4'b0000);
      wait_until(n + 11);
      rr = cyc + 1;
      reset = 1'b1;
      wait_until(rr + 5);
      check("midrst_press_early", press, 4'b0000);
      wait_until(rr + 6);
      check("midrst_repress", press, 4'b0100);
      check("midrst_reheld", held, 4'b0100);
      button[1] = 1'b1;
      wait_until(rr + 20);
      check("final_idle_held", held, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side front end for the `chasy` clock. It turns the four raw, bouncing push-buttons into clean single-cycle `press` events, plus a debounced `held` level that the timekeeping and time-setting logic consume. With auto-repeat compiled in, a long press also produces periodic repeat pulses for fast digit setting. It sits between the board pins and `chasy`'s button input.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a new level must stay stable before it is accepted (20 ms at 50 MHz). Must be ≥1.
- `LONG_CYCLES`, default 50_000_000: cycles in the pressed state before the first repeat pulse. Must be ≥1.
- `REPEAT_CYCLES`, default 10_000_000: cycles between subsequent repeat pulses. Must be ≥1.
- `clock`  input  1  single system clock; all logic is on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `button`  input  [0:3]  raw pins, active-low (0 = pressed), asynchronous to `clock`.
- `press`  output  [0:3]  one-cycle pulse per accepted press and per repeat; active-high.
- `held`  output  [0:3]  debounced pressed level; active-high.

## Operation
- Each bit is conditioned independently by an identical channel. There is no cross-channel interaction, and any number of bits may pulse in the same cycle.
- Each channel uses a 2-FF synchronizer. Both flops reset to 1 (released).
- Channel FSM states are IDLE, DEB_PRESS, PRESSED and DEB_RELEASE.
  - IDLE: if the synced level is pressed, go to DEB_PRESS and clear `cnt`.
  - DEB_PRESS: if the synced level is released, return to IDLE with no output. Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, go to PRESSED and pulse `press`; else increment `cnt`.
  - PRESSED: if the synced level is released, go to DEB_RELEASE and clear `cnt`.
  - DEB_RELEASE: if the synced level is pressed, return to PRESSED with no new `press` pulse. Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, go to IDLE; else increment `cnt`.
- `held` is 1 in PRESSED and DEB_RELEASE, and 0 otherwise.
- All outputs are registered.
- `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`. The repeat counter width is `$clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1)`. Neither counter ever wraps, because both are compared and reloaded before overflow.
- Reset mid-operation: every channel returns to IDLE and all counters clear. A button still held through reset release is detected as a fresh press after full debounce.
- No release event is produced.

## Timing
- Reset values: `press`=0, `held`=0, FSM in IDLE, synchronizers at 1, all counters at 0.
- Press latency: let edge N be the first edge that samples `button[i]`=0, with the pin stable afterwards. `press[i]` and `held[i]` go high at edge N+DEBOUNCE_CYCLES+2. `press[i]` is high for exactly one cycle.
- Release latency: let edge M be the first edge that samples the pin at 1, with the pin stable afterwards. `held[i]` falls at edge M+DEBOUNCE_CYCLES+2.
- A pressed glitch shorter than DEBOUNCE_CYCLES produces no pulse. A released glitch shorter than DEBOUNCE_CYCLES produces no second press.
- Repeat timing (macro enabled): let E be the edge that entered PRESSED with a `press` pulse.
  - Repeat pulses occur at E+LONG_CYCLES, then every REPEAT_CYCLES, while the channel stays in PRESSED.
  - The repeat counter clears on every entry to PRESSED, including a return from DEB_RELEASE.
  - The repeat counter holds its value in other states.

## Configuration
- Macro: `BUTTON_AUTOREPEAT_EN`.
- Defined: the repeat counter and repeat pulses are present as described under Timing.
- Undefined: the repeat counter is not synthesized, and `press` pulses only once per accepted press. `LONG_CYCLES` and `REPEAT_CYCLES` are ignored.

## Structure
- Shared package `chasy_pkg` holds:
  - `NUM_BUTTONS = 4`;
  - the channel state enum `btn_state_t` with values IDLE, DEB_PRESS, PRESSED, DEB_RELEASE;
  - the default cycle constants used by `chasy` and this block.
- Sub-module `button_channel` contains the synchronizer, FSM and counters for one bit. `button_conditioner` instantiates it `NUM_BUTTONS` times in a generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3.
- Reset behaviour: hold `reset`=0 with `button`=4'b0000 → `press`=0 and `held`=0 throughout. Release reset at edge R → all four bits pulse `press` at edge R+6.
- Clean press, macro off: drive `button[1]`=0 from edge N for 20 cycles, then 1 from edge M → exactly one `press[1]` pulse, at N+6. `held[1]` rises at N+6 and falls at M+6. Other bits stay 0.
- Bounce rejection: drive `button[2]` low for 3 cycles, then high → no `press[2]`, and `held[2]` stays 0. While held, a 3-cycle high glitch on `button[2]` → no second pulse, and `held` stays 1.
- Auto-repeat, macro on: drive `button[0]` low from edge N, releasing so that edge N+27 first samples 1 → `press[0]` pulses at N+6, N+16, N+19, N+22, N+25 and N+28, and no later pulses occur.
- Simultaneous press: `button[0]` and `button[3]` go low in the same cycle → `press[0]` and `press[3]` pulse in the same cycle, N+6.
- Reset mid-hold: with `button[1]` in PRESSED, assert `reset` → `held[1]`=0 at the next edge. Deassert reset with the pin still low → a fresh `press[1]` at R+6.
